// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: loader write port over two round-robin hart fetch ports.
// Loader port is built only when IMEM_ARB_LOADER_EN is defined; otherwise ld_* are ignored.
module imem_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f0_req,
    input  logic [ADDR_W-1:0] f0_addr,
    output logic              f0_gnt,
    input  logic              f0_flush,
    output logic              f0_rvalid,
    output logic [DATA_W-1:0] f0_rdata,
    input  logic              f1_req,
    input  logic [ADDR_W-1:0] f1_addr,
    output logic              f1_gnt,
    input  logic              f1_flush,
    output logic              f1_rvalid,
    output logic [DATA_W-1:0] f1_rdata,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H0   = 2'd1,
        H1   = 2'd2
    } rtag_t;

    rtag_t             rtag_q, rtag_d;
    logic              rr_last_q, rr_last_d;   // 1: hart 1 was granted last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ld_act;

`ifdef IMEM_ARB_LOADER_EN
    assign ld_act = ld_valid;
`else
    // Reduces to constant 0 while still consuming the unused loader inputs.
    assign ld_act = &{1'b0, ld_valid, ld_addr, ld_data};
`endif

    always_comb begin
        f0_gnt    = 1'b0;
        f1_gnt    = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        addr_d    = addr_q;
        rtag_d    = IDLE;
        rr_last_d = rr_last_q;
        if (ld_act) begin
            ld_ready  = 1'b1;
            mem_we    = 1'b1;
            addr_d    = ld_addr;
            mem_wdata = ld_data;
        end else if (f0_req && (!f1_req || rr_last_q)) begin
            f0_gnt    = 1'b1;
            addr_d    = f0_addr;
            rr_last_d = 1'b0;
            rtag_d    = f0_flush ? IDLE : H0;
        end else if (f1_req) begin
            f1_gnt    = 1'b1;
            addr_d    = f1_addr;
            rr_last_d = 1'b1;
            rtag_d    = f1_flush ? IDLE : H1;
        end
    end

    assign mem_addr = addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtag_q    <= IDLE;
            rr_last_q <= 1'b1;
            addr_q    <= '0;
        end else begin
            rtag_q    <= rtag_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
        end
    end

    assign f0_rvalid = (rtag_q == H0) && !f0_flush;
    assign f1_rvalid = (rtag_q == H1) && !f1_flush;
    assign f0_rdata  = mem_rdata;
    assign f1_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous-read memory model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_mem = 1'b1;
    logic        f0_req = 1'b0, f1_req = 1'b0;
    logic [8:0]  f0_addr = '0, f1_addr = '0;
    logic        f0_flush = 1'b0, f1_flush = 1'b0;
    logic        f0_gnt, f1_gnt, f0_rvalid, f1_rvalid;
    logic [31:0] f0_rdata, f1_rdata;
    logic        ld_valid = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [512];

    int total = 0;
    int bad = 0;

    imem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .f0_req(f0_req), .f0_addr(f0_addr), .f0_gnt(f0_gnt), .f0_flush(f0_flush),
        .f0_rvalid(f0_rvalid), .f0_rdata(f0_rdata),
        .f1_req(f1_req), .f1_addr(f1_addr), .f1_gnt(f1_gnt), .f1_flush(f1_flush),
        .f1_rvalid(f1_rvalid), .f1_rdata(f1_rdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents default to 0xA0000000 | address, with one marker word.
    always @(posedge clk) begin
        if (rst_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 | i;
            mem[16]   <= 32'hDEAD_BEEF;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic r0, input logic [8:0] a0,
                         input logic r1, input logic [8:0] a1,
                         input logic fl0, input logic fl1,
                         input logic lv, input logic [8:0] la, input logic [31:0] ld);
        @(negedge clk);
        rst = r; f0_req = r0; f0_addr = a0; f1_req = r1; f1_addr = a1;
        f0_flush = fl0; f1_flush = fl1; ld_valid = lv; ld_addr = la; ld_data = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    endtask

    initial begin
        logic [8:0]  prev_a;
        logic        prev_h;
        logic        h;

        // reset state
        drive(1'b1, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        rst_mem = 1'b0;
        chk("rst_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
        chk("rst_f1_rvalid", {31'b0, f1_rvalid}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);

        // single f0 fetch
        drive(1'b0, 1'b1, 9'h010, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("f0_gnt", {31'b0, f0_gnt}, 32'd1);
        chk("f0_only_f1_gnt", {31'b0, f1_gnt}, 32'd0);
        chk("f0_mem_addr", {23'b0, mem_addr}, 32'h010);
        chk("f0_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f0_first_rvalid", {31'b0, f0_rvalid}, 32'd0);
        idle();
        chk("f0_rvalid", {31'b0, f0_rvalid}, 32'd1);
        chk("f0_rdata", f0_rdata, 32'hDEAD_BEEF);
        chk("f0_resp_f1_rvalid", {31'b0, f1_rvalid}, 32'd0);
        chk("idle_addr_hold", {23'b0, mem_addr}, 32'h010);
        chk("idle_f0_gnt", {31'b0, f0_gnt}, 32'd0);

        // single f1 fetch leaves hart 1 as last granted
        drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h031, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("f1_gnt", {31'b0, f1_gnt}, 32'd1);
        chk("f1_only_f0_gnt", {31'b0, f0_gnt}, 32'd0);
        chk("f1_mem_addr", {23'b0, mem_addr}, 32'h031);

        // both requesting: strict alternation starting with hart 0
        prev_h = 1'b1;
        prev_a = 9'h031;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 9'h020, 1'b1, 9'h030, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
            h = (i % 2 == 1);
            chk("rr_f0_gnt", {31'b0, f0_gnt}, {31'b0, !h});
            chk("rr_f1_gnt", {31'b0, f1_gnt}, {31'b0, h});
            chk("rr_mem_addr", {23'b0, mem_addr}, h ? 32'h030 : 32'h020);
            chk("rr_f0_rvalid", {31'b0, f0_rvalid}, {31'b0, !prev_h});
            chk("rr_f1_rvalid", {31'b0, f1_rvalid}, {31'b0, prev_h});
            chk("rr_rdata", f0_rdata, 32'hA000_0000 | {23'b0, prev_a});
            prev_h = h;
            prev_a = h ? 9'h030 : 9'h020;
        end
        idle();
        chk("rr_last_f1_rvalid", {31'b0, f1_rvalid}, 32'd1);
        chk("rr_last_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
        chk("rr_last_rdata", f1_rdata, 32'hA000_0030);

`ifdef IMEM_ARB_LOADER_EN
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 9'h020, 1'b1, 9'h030, 1'b0, 1'b0, 1'b1, 9'h005, 32'h1111_1111);
            chk("ld_ready", {31'b0, ld_ready}, 32'd1);
            chk("ld_f0_gnt", {31'b0, f0_gnt}, 32'd0);
            chk("ld_f1_gnt", {31'b0, f1_gnt}, 32'd0);
            chk("ld_mem_we", {31'b0, mem_we}, 32'd1);
            chk("ld_mem_addr", {23'b0, mem_addr}, 32'h005);
            chk("ld_mem_wdata", mem_wdata, 32'h1111_1111);
            chk("ld_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
            chk("ld_f1_rvalid", {31'b0, f1_rvalid}, 32'd0);
        end
        drive(1'b0, 1'b1, 9'h005, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("ld_after_f0_gnt", {31'b0, f0_gnt}, 32'd1);
        chk("ld_after_mem_we", {31'b0, mem_we}, 32'd0);
        idle();
        chk("ld_readback_rvalid", {31'b0, f0_rvalid}, 32'd1);
        chk("ld_readback_rdata", f0_rdata, 32'h1111_1111);
`else
        drive(1'b0, 1'b1, 9'h020, 1'b1, 9'h030, 1'b0, 1'b0, 1'b1, 9'h005, 32'h1111_1111);
        chk("nold_ready", {31'b0, ld_ready}, 32'd0);
        chk("nold_mem_we", {31'b0, mem_we}, 32'd0);
        chk("nold_mem_wdata", mem_wdata, 32'd0);
        chk("nold_f0_gnt", {31'b0, f0_gnt}, 32'd1);
        chk("nold_f1_gnt", {31'b0, f1_gnt}, 32'd0);
        chk("nold_mem_addr", {23'b0, mem_addr}, 32'h020);
        drive(1'b0, 1'b1, 9'h005, 1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 9'h005, 32'h1111_1111);
        chk("nold_f0_gnt2", {31'b0, f0_gnt}, 32'd1);
        chk("nold_rvalid", {31'b0, f0_rvalid}, 32'd1);
        chk("nold_rdata", f0_rdata, 32'hA000_0020);
        idle();
        chk("nold_readback_rvalid", {31'b0, f0_rvalid}, 32'd1);
        chk("nold_readback_rdata", f0_rdata, 32'hA000_0005);
`endif

        // flush on the response cycle
        drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h030, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("fl_f1_gnt", {31'b0, f1_gnt}, 32'd1);
        drive(1'b0, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b1, 1'b0, 9'h0, 32'h0);
        chk("fl_resp_f1_rvalid", {31'b0, f1_rvalid}, 32'd0);
        chk("fl_resp_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
        // flush on the grant cycle
        drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h030, 1'b0, 1'b1, 1'b0, 9'h0, 32'h0);
        chk("flg_f1_gnt", {31'b0, f1_gnt}, 32'd1);
        chk("flg_mem_addr", {23'b0, mem_addr}, 32'h030);
        idle();
        chk("flg_f1_rvalid", {31'b0, f1_rvalid}, 32'd0);

        // reset one cycle after an f0 grant
        drive(1'b0, 1'b1, 9'h010, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("pre_rst_f0_gnt", {31'b0, f0_gnt}, 32'd1);
        drive(1'b1, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("mid_rst_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
        chk("mid_rst_mem_addr", {23'b0, mem_addr}, 32'd0);
        drive(1'b1, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("mid_rst_f0_rvalid2", {31'b0, f0_rvalid}, 32'd0);
        drive(1'b0, 1'b1, 9'h020, 1'b1, 9'h030, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("post_rst_f0_rvalid", {31'b0, f0_rvalid}, 32'd0);
        chk("post_rst_tie_f0_gnt", {31'b0, f0_gnt}, 32'd1);
        chk("post_rst_tie_f1_gnt", {31'b0, f1_gnt}, 32'd0);
        idle();
        chk("post_rst_resp_rvalid", {31'b0, f0_rvalid}, 32'd1);
        chk("post_rst_resp_rdata", f0_rdata, 32'hA000_0020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
